// File: rtl/reset_sequencer.sv
// reset_sequencer: debounced button and PLL-lock supervised, staged active-low reset release (optional RESET_SEQ_ACK_EN).
// Latency: 2-cycle input sync; stage 0 releases on the RESET_CYCLES-th enabled cycle in HOLD, later stages every STAGE_GAP cycles.
// Backpressure: none by default; with RESET_SEQ_ACK_EN each next stage also waits for stage_ack of the newest released stage.
module reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int RESET_CYCLES    = 131071,
    parameter int STAGE_GAP       = 1024,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int LONG_CYCLES     = 4000000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic                  pll_locked,
    input  logic                  button,
`ifdef RESET_SEQ_ACK_EN
    input  logic [NUM_STAGES-1:0] stage_ack,
`endif
    output logic [NUM_STAGES-1:0] nreset_out,
    output logic                  all_released,
    output logic                  reconfigure
);

    localparam int HW = $clog2(RESET_CYCLES) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LW = $clog2(LONG_CYCLES) + 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_TERM = LW'(LONG_CYCLES);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    logic            pll_meta, pll_sync;
    logic            btn_meta, btn_sync;
    logic [DW-1:0]   deb_cnt;
    logic            deb, deb_q;
    logic [LW-1:0]   long_cnt;
    logic [1:0]      state;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            press;
    logic            restart;
    logic            ack_ok;
    logic [NUM_STAGES-1:0] next_mask;

    assign press   = deb & ~deb_q;
    assign restart = ~pll_sync | press;

    // Outputs are a thermometer code, so releasing the next stage is a shift-in of a one.
    assign next_mask = (nreset_out << 1) | NUM_STAGES'(1);

`ifdef RESET_SEQ_ACK_EN
    // Ack of the most recently released stage (top bit of the thermometer) gates the next release.
    assign ack_ok = |(stage_ack & nreset_out & ~(nreset_out >> 1));
`else
    assign ack_ok = 1'b1;
`endif

    // Two-flop synchronisers for the asynchronous PLL lock and raw button.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pll_meta <= 1'b0;
            pll_sync <= 1'b0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            pll_meta <= pll_locked;
            pll_sync <= pll_meta;
            btn_meta <= button;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: adopt the synchronised level after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            deb_cnt <= '0;
            deb     <= 1'b0;
            deb_q   <= 1'b0;
        end else begin
            deb_q <= deb;
            if (btn_sync == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= btn_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Long press: saturating count while pressed, single reconfigure pulse on reaching LONG_CYCLES.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            long_cnt    <= '0;
            reconfigure <= 1'b0;
        end else if (!deb) begin
            long_cnt    <= '0;
            reconfigure <= 1'b0;
        end else begin
            reconfigure <= (long_cnt == LONG_LAST);
            if (long_cnt != LONG_TERM) begin
                long_cnt <= long_cnt + 1'b1;
            end
        end
    end

    // Sequencer: HOLD counts enabled locked cycles, RELEASE steps stages, RUN holds; loss or press re-enters HOLD.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= ST_HOLD;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            nreset_out   <= '0;
            all_released <= 1'b0;
        end else if (state != ST_HOLD && restart) begin
            // Re-entry takes priority over any release due in the same cycle.
            state        <= ST_HOLD;
            hold_cnt     <= '0;
            gap_cnt      <= '0;
            nreset_out   <= '0;
            all_released <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (restart) begin
                        hold_cnt <= '0;
                    end else if (enable) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt   <= '0;
                            gap_cnt    <= '0;
                            nreset_out <= NUM_STAGES'(1);
                            if (NUM_STAGES == 1) begin
                                state        <= ST_RUN;
                                all_released <= 1'b1;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt != GAP_LAST) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end else if (ack_ok) begin
                        gap_cnt    <= '0;
                        nreset_out <= next_mask;
                        if (&next_mask) begin
                            state        <= ST_RUN;
                            all_released <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                end
                default: begin
                    state        <= ST_HOLD;
                    hold_cnt     <= '0;
                    gap_cnt      <= '0;
                    nreset_out   <= '0;
                    all_released <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer with a behavioural reference model.
// Model pushes expected output-change events; a monitor pops one per observed DUT output change.
// Directed scenarios are followed by a randomized stretch of enable/pll/button activity.
module tb_reset_sequencer;

    localparam int NS   = 3;
    localparam int RC   = 16;
    localparam int GAP  = 4;
    localparam int DEB  = 8;
    localparam int LONG = 32;

    typedef struct {
        int            cyc;
        logic [NS+1:0] val;
    } ev_t;

    logic          clk;
    logic          n_reset;
    logic          enable;
    logic          pll_locked;
    logic          button;
    logic [NS-1:0] nreset_out;
    logic          all_released;
    logic          reconfigure;
`ifdef RESET_SEQ_ACK_EN
    logic [NS-1:0] stage_ack;
`endif

    ev_t evq[$];
    int  cyc = 0;
    bit  done = 0;
    int  vectors = 0;
    int  miscompares = 0;

    reset_sequencer #(
        .NUM_STAGES(NS),
        .RESET_CYCLES(RC),
        .STAGE_GAP(GAP),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES(LONG)
    ) dut (
        .clk(clk),
        .n_reset(n_reset),
        .enable(enable),
        .pll_locked(pll_locked),
        .button(button),
`ifdef RESET_SEQ_ACK_EN
        .stage_ack(stage_ack),
`endif
        .nreset_out(nreset_out),
        .all_released(all_released),
        .reconfigure(reconfigure)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: input delay lines, stable-run debounce, enabled-cycle hold count,
    // and stage count derived as 1 + elapsed/GAP since stage 0 released.
    bit m_p1, m_p2, m_b1, m_b2, m_deb, m_debq, m_pulse, m_seq;
    int m_hold, m_since, m_rel, m_run, m_long;
    logic [NS+1:0] prev_exp;

    always @(posedge clk or negedge n_reset) begin
        logic [NS+1:0] e;
        bit press, lost;
        // clk is high only when this wake-up is a rising clock edge; async resets are applied with clk low.
        if (clk) cyc++;
        if (!n_reset) begin
            m_p1 = 0; m_p2 = 0; m_b1 = 0; m_b2 = 0;
            m_deb = 0; m_debq = 0; m_pulse = 0; m_seq = 0;
            m_hold = 0; m_since = 0; m_rel = 0; m_run = 0; m_long = 0;
        end else begin
            press = m_deb && !m_debq;
            lost  = !m_p2;
            if (!m_seq) begin
                if (lost || press) m_hold = 0;
                else if (enable) begin
                    m_hold++;
                    if (m_hold == RC) begin
                        m_hold = 0; m_seq = 1; m_rel = 1; m_since = 0;
                    end
                end
            end else if (lost || press) begin
                m_seq = 0; m_rel = 0; m_hold = 0;
            end else if (m_rel < NS) begin
                m_since++;
                m_rel = (1 + m_since / GAP < NS) ? 1 + m_since / GAP : NS;
            end
            if (m_deb) begin
                if (m_long < LONG) begin
                    m_long++;
                    m_pulse = (m_long == LONG);
                end else m_pulse = 0;
            end else begin
                m_long = 0; m_pulse = 0;
            end
            m_debq = m_deb;
            if (m_b2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin m_deb = m_b2; m_run = 0; end
            end else m_run = 0;
            m_p2 = m_p1; m_p1 = pll_locked;
            m_b2 = m_b1; m_b1 = button;
        end
        e = {m_pulse, (m_rel == NS), NS'((1 << m_rel) - 1)};
        if (cyc > 0 && e !== prev_exp) begin
            evq.push_back('{cyc, e});
            prev_exp = e;
        end
    end

    // Monitor: every observed DUT output change must match the next expected event, value and cycle.
    initial begin
        logic [NS+1:0] cur, last;
        ev_t ev;
        last = 'x;
        forever begin
            @(negedge clk or negedge n_reset);
            #1;
            if (done) break;
            cur = {reconfigure, all_released, nreset_out};
            if (cyc > 0 && cur !== last) begin
                last = cur;
                vectors++;
                if (evq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, cur);
                end else begin
                    ev = evq.pop_front();
                    if (ev.val !== cur || ev.cyc != cyc) begin
                        miscompares++;
                        $display("FAIL output_event got=%b@cyc%0d required=%b@cyc%0d", cur, cyc, ev.val, ev.cyc);
                    end
                end
            end
        end
        vectors++;
        if (evq.size() != 0) begin
            miscompares++;
            $display("FAIL pending_events got=%0d unobserved required=0 (next %b@cyc%0d)",
                     evq.size(), evq[0].val, evq[0].cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got=no finish required=finish");
        $fatal(1, "timeout");
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pll_blip();
        pll_locked = 1'b0;
        cycles(1);
        pll_locked = 1'b1;
    endtask

    // Stimulus: directed scenarios, then randomized activity.
    initial begin
        int btn_left;
        n_reset = 1'b0; enable = 1'b1; pll_locked = 1'b1; button = 1'b0;
`ifdef RESET_SEQ_ACK_EN
        stage_ack = '1;
`endif
        cycles(3);
        n_reset = 1'b1;
        // Basic power-up sequence to RUN.
        cycles(40);
        // Short glitch in RUN, then a real press.
        button = 1'b1; cycles(5); button = 1'b0; cycles(20);
        button = 1'b1; cycles(12); button = 1'b0; cycles(40);
        // Enable toggling while in HOLD.
        pll_blip();
        for (int i = 0; i < 60; i++) begin
            enable = i[0];
            cycles(1);
        end
        enable = 1'b1; cycles(30);
        // PLL loss while at 011.
        pll_blip(); cycles(22);
        pll_blip(); cycles(40);
        // Two long presses.
        button = 1'b1; cycles(100); button = 1'b0; cycles(30);
        button = 1'b1; cycles(100); button = 1'b0; cycles(40);
        // Asynchronous reset mid-release, applied between clock edges.
        pll_blip(); cycles(22);
        #2 n_reset = 1'b0;
        cycles(3);
        n_reset = 1'b1;
        cycles(40);
        // Randomized stretch.
        btn_left = 0;
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            if (btn_left == 0) begin
                button = ~button;
                btn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60) : $urandom_range(1, 12);
            end
            btn_left--;
            pll_locked = ($urandom_range(0, 99) != 0);
            cycles(1);
        end
        button = 1'b0; pll_locked = 1'b1; enable = 1'b1;
        cycles(60);
        done = 1'b1;
    end

endmodule
